// File: rtl/scan_chain_seq.sv
// WIDTH-bit scan register split into CHAINS parallel chains, with a one-pulse
// automatic shift/capture sequencer, manual shift and functional capture.
module scan_chain_seq #(
  parameter int WIDTH  = 16,
  parameter int CHAINS = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              scan_en_i,
  input  logic [CHAINS-1:0] scan_in_i,
  input  logic              start_i,
  output logic [WIDTH-1:0]  q_o,
  output logic [CHAINS-1:0] scan_out_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int L = WIDTH / CHAINS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   shift_d;
  logic               busy_q;
  logic               done_q;

  // Every chain moves one bit toward its LSB; scan_in enters at the chain MSB.
  always_comb begin
    shift_d = q_q;
    for (int c = 0; c < CHAINS; c++) begin
      for (int i = 0; i < L - 1; i++) begin
        shift_d[c*L+i] = q_q[c*L+i+1];
      end
      shift_d[c*L+L-1] = scan_in_i[c];
    end
  end

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (scan_en_i) begin
            q_q <= shift_d;
          end else begin
            q_q <= d_i;
          end
        end
        S_SHIFT: begin
          q_q   <= shift_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          q_q     <= d_i;
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < CHAINS; c++) begin : g_scan_out
    assign scan_out_o[c] = q_q[c*L];
  end

  assign q_o    = q_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_scan_chain_seq.sv
// Bench for scan_chain_seq (WIDTH=8, CHAINS=2): directed scenarios plus random
// traffic, all compared every cycle against a sequence-time reference model.
module tb_scan_chain_seq;

  localparam int W = 8;
  localparam int C = 2;
  localparam int L = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d = '0;
  logic         scan_en = 1'b0;
  logic [C-1:0] scan_in = '0;
  logic         start = 1'b0;
  logic [W-1:0] q;
  logic [C-1:0] scan_out;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  scan_chain_seq #(.WIDTH(W), .CHAINS(C), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .d_i        (d),
    .scan_en_i  (scan_en),
    .scan_in_i  (scan_in),
    .start_i    (start),
    .q_o        (q),
    .scan_out_o (scan_out),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: register image plus "edges since launch" (-1 when idle).
  logic [W-1:0] mq;
  int           t = -1;
  bit           mvalid = 0;

  function automatic logic [W-1:0] mshift(input logic [W-1:0] v, input logic [C-1:0] si);
    int r = 0;
    for (int c = 0; c < C; c++) begin
      int ch = (int'(v) >> (c * L)) & ((1 << L) - 1);
      ch = (ch >> 1) | (int'(si[c]) << (L - 1));
      r = r | (ch << (c * L));
    end
    return W'(r);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq = '0;
      t = -1;
      mvalid = 1;
    end else if (t < 0) begin
      if (start) t = 0;
      else if (scan_en) mq = mshift(mq, scan_in);
      else mq = d;
    end else begin
      if (t < L) mq = mshift(mq, scan_in);
      else if (t == L) mq = d;
      t++;
      if (t > L + 1) t = -1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [C-1:0] so_exp;
      for (int c = 0; c < C; c++) so_exp[c] = mq[c*L];
      chk("model_q", q, mq);
      chk("model_scan_out", 8'(scan_out), 8'(so_exp));
      chk("model_busy", 8'(busy), 8'((t >= 0 && t <= L) ? 1 : 0));
      chk("model_done", 8'(done), 8'((t == L + 1) ? 1 : 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    int edges;
    logic [1:0] so_seq [4];
    so_seq[0] = 2'b01; so_seq[1] = 2'b10; so_seq[2] = 2'b01; so_seq[3] = 2'b10;

    // Reset with hostile inputs
    rst_n = 0; d = 8'hFF; start = 1;
    tick(); tick();
    chk("rst_q", q, 8'h00);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_scan_out", 8'(scan_out), 8'h0);

    // Functional capture
    rst_n = 1; start = 0; scan_en = 0; d = 8'hA5;
    tick(); chk("cap_a5", q, 8'hA5);
    d = 8'h5A;
    tick(); chk("cap_5a", q, 8'h5A);

    // Manual shift
    d = 8'h00; tick();
    scan_en = 1; scan_in = 2'b11;
    tick(); chk("man_q1", q, 8'h88); chk("man_so1", 8'(scan_out), 8'h0);
    tick(); chk("man_so2", 8'(scan_out), 8'h0);
    tick(); chk("man_so3", 8'(scan_out), 8'h0);
    tick(); chk("man_q4", q, 8'hFF); chk("man_so4", 8'(scan_out), 8'h3);

    // Automatic sequence
    scan_en = 0; d = 8'hA5; tick();
    scan_in = 2'b01; d = 8'h3C; start = 1;
    tick(); start = 0;
    chk("seq_e0_q", q, 8'hA5); chk("seq_e0_busy", 8'(busy), 8'h1);
    chk("seq_so0", 8'(scan_out), 8'(so_seq[0]));
    for (int k = 1; k < 4; k++) begin
      tick(); chk("seq_so", 8'(scan_out), 8'(so_seq[k]));
    end
    tick(); chk("seq_e4_q", q, 8'h0F);
    tick(); chk("seq_e5_q", q, 8'h3C); chk("seq_e5_done", 8'(done), 8'h1);
    chk("seq_e5_busy", 8'(busy), 8'h0);
    tick(); chk("seq_e6_done", 8'(done), 8'h0); chk("seq_e6_busy", 8'(busy), 8'h0);

    // start/scan_en held throughout a sequence
    d = 8'hA5; tick();
    start = 1; scan_en = 1; scan_in = 2'b01; d = 8'h3C;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) ndone++;
      if (k == 5) chk("hold_e5_done", 8'(done), 8'h1);
    end
    chk("hold_done_count", 8'(ndone), 8'h1);
    chk("hold_final_q", q, 8'h3C);
    tick(); chk("hold_e6_busy", 8'(busy), 8'h0);
    tick(); chk("hold_relaunch_busy", 8'(busy), 8'h1);
    start = 0; scan_en = 0;
    edges = 0;
    while (!done && edges < 20) begin tick(); edges++; end
    chk("hold_relaunch_done", 8'(done), 8'h1);
    tick();

    // Reset mid-sequence
    d = 8'hA5; tick();
    start = 1; tick(); start = 0;
    tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("midrst_q", q, 8'h00); chk("midrst_busy", 8'(busy), 8'h0);
    ndone = 0;
    d = 8'h00;
    for (int k = 0; k < 6; k++) begin tick(); if (done) ndone++; end
    chk("midrst_no_done", 8'(ndone), 8'h0);
    start = 1; d = 8'h77; tick(); start = 0;
    edges = 1;
    while (!done && edges < 20) begin tick(); edges++; end
    chk("fresh_done_edges", 8'(edges), 8'(L + 2));
    chk("fresh_q", q, 8'h77);
    tick(); chk("fresh_idle_done", 8'(done), 8'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n   = ($urandom_range(0, 63) != 0);
      start   = ($urandom_range(0, 7) == 0);
      scan_en = $urandom_range(0, 1) == 1;
      scan_in = C'($urandom);
      d       = W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_chain_seq.md
Name: scan_chain_seq

Overview:
- Parametrised successor to the single scan flip-flop: a WIDTH-bit scan register split into CHAINS equal-length parallel scan chains.
- Operating modes, in priority order:
  - automatic shift/capture sequencer, started by a single pulse;
  - manual shift;
  - functional capture.
- Sits between functional logic and the test controller, so the test controller can load and unload patterns without driving per-cycle scan_en.

Parameters:
- WIDTH, 16, total register bits; must be divisible by CHAINS.
- CHAINS, 2, number of parallel scan chains. Chain length L = WIDTH/CHAINS, L >= 2.
- CNT_W, 8, width of the internal shift counter; must satisfy 2^CNT_W > L.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- d  input  WIDTH  functional data.
- scan_en  input  1  manual shift enable.
- scan_in  input  CHAINS  serial input, one bit per chain.
- start  input  1  single-cycle pulse that launches an automatic sequence.
- q  output  WIDTH  register contents.
- scan_out  output  CHAINS  serial output per chain; scan_out[c] = q[c*L] (flop-driven, no combinational path from inputs).
- busy  output  1  high in SHIFT and CAPTURE states.
- done  output  1  high for exactly one cycle, in DONE state.

Behaviour:
- Reset:
  - Sampled on the clk rising edge when rst=0.
  - Results: q=0, state=IDLE, counter=0, busy=0, done=0.
  - Reset overrides everything, including a sequence in progress.
- Chain mapping: chain c owns bits q[c*L+L-1 : c*L].
- Shift operation, applied to every chain simultaneously:
  - q[c*L+i] <= q[c*L+i+1] for i = 0..L-2;
  - q[c*L+L-1] <= scan_in[c].
  - Data moves toward the LSB; the old q[c*L] is lost after it is presented on scan_out.
- States: IDLE, SHIFT, CAPTURE, DONE.
  - IDLE:
    - start=1: go to SHIFT, counter=0, q holds (start has priority over scan_en and functional capture).
    - else scan_en=1: shift.
    - else: q <= d.
  - SHIFT:
    - Shift on every edge and increment counter.
    - When counter == L-1 on an edge, that edge performs the last shift and the state moves to CAPTURE.
    - Exactly L shifts occur.
  - CAPTURE: q <= d on one edge, then go to DONE.
  - DONE: q holds; the next edge goes to IDLE.
- busy and done are decoded from registered state:
  - start sampled at edge E0;
  - busy is high from after E0 until after edge E0+L+1;
  - done is high for the cycle between edges E0+L+1 and E0+L+2.
- In SHIFT, CAPTURE and DONE, start and scan_en are ignored; there is no restart and no abort except reset.
- start and scan_en both high in IDLE: start wins; the sequence launches and no manual shift occurs that edge.
- Counter does not wrap within a sequence; it is cleared on entry to SHIFT.
- scan_out changes only on clock edges.

Test Plan:
Bench configuration for all scenarios: WIDTH=8, CHAINS=2, L=4.
1. Reset: rst=0 for 2 edges with d=8'hFF, start=1 -> q=8'h00, busy=0, done=0, scan_out=2'b00.
2. Functional capture: rst=1, scan_en=0, start=0, d=8'hA5 -> q=8'hA5 after one edge. Then d=8'h5A -> q=8'h5A.
3. Manual shift:
   - Setup: q=8'h00, scan_en=1, scan_in=2'b11 held.
   - After 4 edges: q=8'hFF.
   - After the first edge: q=8'h88.
   - scan_out stays 2'b00 until the 4th edge, then 2'b11.
4. Automatic sequence:
   - Setup: q=8'hA5, scan_in=2'b01 held, d=8'h3C, pulse start at E0.
   - After E0: q=8'hA5, busy=1.
   - scan_out sampled after E0..E3: chain0 = 1,0,1,0; chain1 = 0,1,0,1.
   - After E4: q=8'h0F.
   - After E5: q=8'h3C, done=1, busy=0.
   - After E6: done=0, IDLE.
5. Ignored inputs while busy:
   - Setup: q=8'hA5, start=1 and scan_en=1 held through the sequence, scan_in=2'b01, d=8'h3C.
   - done pulses exactly once, at E0+5; final q=8'h3C.
   - Because start is still held, a new sequence launches at the first IDLE edge after DONE.
6. Reset mid-sequence: rst=0 at edge E0+2 of an automatic sequence -> q=8'h00, busy=0, no done pulse. A fresh start then completes normally in L+2 edges.
